// File: rtl/card_shoe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : card_shoe_pkg
// Desc     : Shared card type, deck size, FSM encoding and ordered-deck helper.
// Revision : 1.0 - initial release
// ============================================================================
package card_shoe_pkg;

  typedef logic [3:0] card_t;

  localparam int DECK_SIZE = 52;
  localparam int STATE_W   = 3;

  localparam logic [STATE_W-1:0] S_INIT  = 3'd0;
  localparam logic [STATE_W-1:0] S_PICK  = 3'd1;
  localparam logic [STATE_W-1:0] S_SWAP  = 3'd2;
  localparam logic [STATE_W-1:0] S_READY = 3'd3;
  localparam logic [STATE_W-1:0] S_EMPTY = 3'd4;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Rank 0 is the ace, ranks 10..12 are face cards worth 10.
  function automatic card_t ordered_card(input logic [5:0] k, input card_t ace);
    logic [5:0] r;
    r = k % 6'd13;
    if (r == 6'd0) return ace;
    if (r <= 6'd9) return r[3:0] + 4'd1;
    return 4'd10;
  endfunction

endpackage
`default_nettype wire

// File: rtl/card_shoe_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Desc     : 16-bit right-shifting Galois LFSR with seed load and step enable.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16
  import card_shoe_pkg::*;
#(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        LOAD,
  input  logic [15:0] SEED,
  input  logic        EN,
  output logic [15:0] Q
);

  logic [15:0] r_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_q <= DEFAULT_SEED;
    end else if (LOAD) begin
      r_q <= SEED;
    end else if (EN) begin
      r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign Q = r_q;

endmodule
`default_nettype wire

// File: rtl/card_shoe.sv
`default_nettype none
// ============================================================================
// Module   : card_shoe
// Desc     : 52-card deck, Fisher-Yates shuffled from an LFSR, dealing one card per REQ.
// Revision : 1.0 - initial release
// ============================================================================
module card_shoe
  import card_shoe_pkg::*;
#(
  parameter bit          SHUFFLE_EN   = 1'b1,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
  parameter int unsigned ACE_VALUE    = 11
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        SHUFFLE,
  input  logic [15:0] SEED,
  input  logic        REQ,
  output card_t       CARD,
  output logic        CARD_VALID,
  output logic        READY,
  output logic        EMPTY,
  output logic [5:0]  CARDS_LEFT,
  output logic        UNDERFLOW
);

  localparam card_t      c_ACE  = ACE_VALUE[3:0];
  localparam logic [5:0] c_DECK = 6'(DECK_SIZE);
  localparam logic [5:0] c_LAST = 6'(DECK_SIZE - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [5:0]         r_k;
  logic [5:0]         r_i;
  logic [5:0]         r_j;
  logic [5:0]         r_ptr;
  card_t              r_card;
  logic               r_card_valid;
  logic               r_underflow;
  card_t              r_deck [DECK_SIZE];

  logic [5:0]         w_j;
  logic [9:0]         w_lfsr_unused;
  logic [15:0]        w_load_seed;
  logic               w_lfsr_en;
  logic               w_deal;
  logic               w_uflow;
  logic               w_pick_ok;

  assign w_load_seed = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
  assign w_pick_ok   = (w_j <= r_i);

  lfsr16 #(
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .LOAD    (SHUFFLE),
    .SEED    (w_load_seed),
    .EN      (w_lfsr_en),
    .Q       ({w_lfsr_unused, w_j})
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (SHUFFLE) begin
      w_next = S_INIT;
    end else begin
      case (r_state)
        S_INIT:  if (r_k == c_LAST) w_next = SHUFFLE_EN ? S_PICK : S_READY;
        S_PICK:  if (w_pick_ok) w_next = S_SWAP;
        S_SWAP:  w_next = (r_i == 6'd1) ? S_READY : S_PICK;
        S_READY: if (REQ && (r_ptr == c_LAST)) w_next = S_EMPTY;
        S_EMPTY: w_next = S_EMPTY;
        default: w_next = S_INIT;
      endcase
    end
  end

  // SHUFFLE suppresses both deal and underflow in the cycle it is sampled.
  always_comb begin
    READY      = 1'b0;
    EMPTY      = 1'b0;
    CARDS_LEFT = 6'd0;
    w_lfsr_en  = 1'b0;
    w_deal     = 1'b0;
    w_uflow    = 1'b0;
    case (r_state)
      S_PICK: w_lfsr_en = 1'b1;
      S_READY: begin
        READY      = 1'b1;
        CARDS_LEFT = c_DECK - r_ptr;
        w_deal     = REQ & ~SHUFFLE;
      end
      S_EMPTY: begin
        EMPTY      = 1'b1;
        CARDS_LEFT = c_DECK - r_ptr;
        w_uflow    = REQ & ~SHUFFLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_k          <= 6'd0;
      r_i          <= 6'd0;
      r_j          <= 6'd0;
      r_ptr        <= 6'd0;
      r_card       <= 4'd0;
      r_card_valid <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_card_valid <= w_deal;
      r_underflow  <= w_uflow;
      if (w_deal) begin
        r_card <= r_deck[r_ptr];
        r_ptr  <= r_ptr + 6'd1;
      end
      if (SHUFFLE) begin
        r_k <= 6'd0;
      end else begin
        case (r_state)
          S_INIT: begin
            r_k   <= r_k + 6'd1;
            r_i   <= c_LAST;
            r_ptr <= 6'd0;
          end
          S_PICK:  if (w_pick_ok) r_j <= w_j;
          S_SWAP:  r_i <= r_i - 6'd1;
          default: ;
        endcase
      end
    end
  end

  // Deck contents need no reset: every path to dealing passes through S_INIT.
  always_ff @(posedge CLK) begin
    if (r_state == S_INIT) begin
      r_deck[r_k] <= ordered_card(r_k, c_ACE);
    end else if (r_state == S_SWAP) begin
      r_deck[r_i] <= r_deck[r_j];
      r_deck[r_j] <= r_deck[r_i];
    end
  end

  assign CARD       = r_card;
  assign CARD_VALID = r_card_valid;
  assign UNDERFLOW  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_card_shoe.sv
`default_nettype none
// ============================================================================
// Module   : tb_card_shoe
// Desc     : Self-checking bench for card_shoe: ordered and shuffled instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_card_shoe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sh0, req0, sh1, req1;
  logic [15:0] seed0, seed1;
  logic [3:0]  card0, card1;
  logic        v0, v1, rdy0, rdy1, emp0, emp1, uf0, uf1;
  logic [5:0]  left0, left1;

  always #5 clk = ~clk;

  card_shoe #(.SHUFFLE_EN(1'b0)) u_dut0 (
    .CLK(clk), .RESET_N(rst_n), .SHUFFLE(sh0), .SEED(seed0), .REQ(req0),
    .CARD(card0), .CARD_VALID(v0), .READY(rdy0), .EMPTY(emp0),
    .CARDS_LEFT(left0), .UNDERFLOW(uf0)
  );

  card_shoe #(.SHUFFLE_EN(1'b1)) u_dut1 (
    .CLK(clk), .RESET_N(rst_n), .SHUFFLE(sh1), .SEED(seed1), .REQ(req1),
    .CARD(card1), .CARD_VALID(v1), .READY(rdy1), .EMPTY(emp1),
    .CARDS_LEFT(left1), .UNDERFLOW(uf1)
  );

  typedef struct packed {
    logic       req;
    logic [3:0] card;
    logic       valid;
    logic [5:0] left;
  } vec_t;

  vec_t vt [12];
  int   n_tests;
  int   n_fail;
  int   exp_deck [52];
  int   seq_a [52];
  int   dealt [52];
  int   last1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ord_card(input int k);
    int r;
    r = k % 13;
    if (r == 0) return 11;
    if (r < 10) return r + 1;
    return 10;
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Reference deck: Fisher-Yates with rejection sampling on the LFSR's low 6 bits.
  task automatic build_deck(input logic [15:0] seed_in);
    logic [15:0] s;
    int j;
    int tmp;
    s = (seed_in == 16'h0000) ? 16'hACE1 : seed_in;
    for (int k = 0; k < 52; k++) exp_deck[k] = ord_card(k);
    for (int i = 51; i >= 1; i--) begin
      j = 64;
      while (j > i) begin
        j = int'(s[5:0]);
        s = lstep(s);
      end
      tmp = exp_deck[i];
      exp_deck[i] = exp_deck[j];
      exp_deck[j] = tmp;
    end
  endtask

  task automatic wait_rdy(input bit sel, input string nm);
    int c;
    c = 0;
    while (((sel ? rdy1 : rdy0) !== 1'b1) && (c < 3000)) begin
      step();
      c++;
    end
    chk({nm, " ready"}, int'(sel ? rdy1 : rdy0), 1);
  endtask

  task automatic shuffle1(input logic [15:0] s, input string nm);
    seed1 = s;
    sh1   = 1'b1;
    step();
    sh1   = 1'b0;
    chk({nm, " ready drop"}, int'(rdy1), 0);
    chk({nm, " card hold"}, int'(card1), last1);
    wait_rdy(1'b1, nm);
    chk({nm, " left full"}, int'(left1), 52);
  endtask

  task automatic deal1(input int n, input int base, input string nm);
    req1 = 1'b1;
    for (int c = 0; c < n; c++) begin
      step();
      if (c == n - 1) req1 = 1'b0;
      chk({nm, " valid"}, int'(v1), 1);
      chk({nm, " card"}, int'(card1), exp_deck[base + c]);
      chk({nm, " left"}, int'(left1), 52 - (base + c + 1));
      dealt[base + c] = int'(card1);
      last1 = exp_deck[base + c];
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sum;
    int diff;
    int hist [16];
    int idx;
    logic [31:0] rs;

    n_tests = 0; n_fail = 0; last1 = 0;
    rst_n = 1'b1;
    sh0 = 1'b0; req0 = 1'b0; seed0 = 16'h0000;
    sh1 = 1'b0; req1 = 1'b0; seed1 = 16'h0000;
    #1 rst_n = 1'b0;
    #2;
    chk("reset card0", int'(card0), 0);
    chk("reset valid0", int'(v0), 0);
    chk("reset ready0", int'(rdy0), 0);
    chk("reset empty0", int'(emp0), 0);
    chk("reset left0", int'(left0), 0);
    chk("reset uflow0", int'(uf0), 0);
    chk("reset card1", int'(card1), 0);
    chk("reset ready1", int'(rdy1), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Ordered deck, single and held requests
    vt[0]  = '{1'b1, 4'd11, 1'b1, 6'd51};
    vt[1]  = '{1'b0, 4'd11, 1'b0, 6'd51};
    vt[2]  = '{1'b1, 4'd2,  1'b1, 6'd50};
    vt[3]  = '{1'b0, 4'd2,  1'b0, 6'd50};
    vt[4]  = '{1'b1, 4'd3,  1'b1, 6'd49};
    vt[5]  = '{1'b0, 4'd3,  1'b0, 6'd49};
    vt[6]  = '{1'b1, 4'd4,  1'b1, 6'd48};
    vt[7]  = '{1'b0, 4'd4,  1'b0, 6'd48};
    vt[8]  = '{1'b1, 4'd5,  1'b1, 6'd47};
    vt[9]  = '{1'b1, 4'd6,  1'b1, 6'd46};
    vt[10] = '{1'b1, 4'd7,  1'b1, 6'd45};
    vt[11] = '{1'b0, 4'd7,  1'b0, 6'd45};

    wait_rdy(1'b0, "t1");
    chk("t1 left full", int'(left0), 52);
    chk("t1 empty", int'(emp0), 0);
    sum = 0;
    for (int t = 0; t < 12; t++) begin
      req0 = vt[t].req;
      step();
      chk("t1 valid", int'(v0), int'(vt[t].valid));
      chk("t1 card", int'(card0), int'(vt[t].card));
      chk("t1 left", int'(left0), int'(vt[t].left));
      if (vt[t].req) sum += int'(card0);
    end
    req0 = 1'b0;

    req0 = 1'b1;
    for (int c = 0; c < 45; c++) begin
      step();
      if (c == 44) req0 = 1'b0;
      chk("t2 card", int'(card0), ord_card(7 + c));
      sum += int'(card0);
    end
    chk("t2 sum", sum, 380);
    chk("t2 empty", int'(emp0), 1);
    chk("t2 left", int'(left0), 0);
    chk("t2 ready", int'(rdy0), 0);
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    chk("t2 underflow", int'(uf0), 1);
    chk("t2 no valid", int'(v0), 0);
    chk("t2 card hold", int'(card0), 10);
    step();
    chk("t2 underflow pulse", int'(uf0), 0);

    // Power-on shuffle with the default seed, held request of 3
    wait_rdy(1'b1, "t6");
    build_deck(16'hACE1);
    chk("t6 left full", int'(left1), 52);
    deal1(3, 0, "t6");
    step();
    chk("t6 valid drop", int'(v1), 0);
    chk("t6 left", int'(left1), 49);
    deal1(49, 3, "pwr");
    chk("pwr empty", int'(emp1), 1);

    // Seeded shuffles: composition, repeatability, seed sensitivity
    shuffle1(16'h1234, "t3a");
    build_deck(16'h1234);
    deal1(52, 0, "t3a");
    for (int v = 0; v < 16; v++) hist[v] = 0;
    for (int k = 0; k < 52; k++) begin
      hist[dealt[k] & 15]++;
      seq_a[k] = dealt[k];
    end
    for (int v = 2; v <= 9; v++) chk("t3 count", hist[v], 4);
    chk("t3 count ace", hist[11], 4);
    chk("t3 count ten", hist[10], 16);
    shuffle1(16'h1234, "t3b");
    deal1(52, 0, "t3b");
    diff = 0;
    for (int k = 0; k < 52; k++) if (dealt[k] != seq_a[k]) diff++;
    chk("t3 repeat diffs", diff, 0);
    shuffle1(16'h5678, "t3c");
    build_deck(16'h5678);
    deal1(52, 0, "t3c");
    diff = 0;
    for (int k = 0; k < 52; k++) if (dealt[k] != seq_a[k]) diff++;
    chk("t3 seeds differ", (diff > 0) ? 1 : 0, 1);

    // REQ and SHUFFLE together: shuffle wins
    shuffle1(16'h0000, "t4pre");
    build_deck(16'h0000);
    deal1(2, 0, "t4pre");
    seed1 = 16'h5678;
    req1  = 1'b1;
    sh1   = 1'b1;
    step();
    req1  = 1'b0;
    sh1   = 1'b0;
    chk("t4 no valid", int'(v1), 0);
    chk("t4 no underflow", int'(uf1), 0);
    chk("t4 ready drop", int'(rdy1), 0);
    chk("t4 card hold", int'(card1), last1);
    wait_rdy(1'b1, "t4");
    chk("t4 left full", int'(left1), 52);
    build_deck(16'h5678);
    deal1(3, 0, "t4post");

    // Asynchronous reset in the middle of a shuffle
    seed1 = 16'h1234;
    sh1   = 1'b1;
    step();
    sh1   = 1'b0;
    for (int c = 0; c < 60; c++) step();
    chk("t5 busy", int'(rdy1), 0);
    rst_n = 1'b0;
    #1;
    chk("t5 card", int'(card1), 0);
    chk("t5 valid", int'(v1), 0);
    chk("t5 ready", int'(rdy1), 0);
    chk("t5 empty", int'(emp1), 0);
    chk("t5 left", int'(left1), 0);
    chk("t5 uflow", int'(uf1), 0);
    last1 = 0;
    #2 rst_n = 1'b1;
    wait_rdy(1'b1, "t5");
    build_deck(16'hACE1);
    deal1(52, 0, "t5post");

    // Random seeds and random request patterns against a queue model
    for (int it = 0; it < 3; it++) begin
      rs = (it == 0) ? 32'd0 : $urandom;
      shuffle1(rs[15:0], "rnd");
      build_deck(rs[15:0]);
      idx = 0;
      for (int c = 0; c < 70; c++) begin
        bit r;
        r = ($urandom_range(0, 3) != 0);
        req1 = r;
        step();
        if (r && idx < 52) begin
          chk("rnd valid", int'(v1), 1);
          chk("rnd card", int'(card1), exp_deck[idx]);
          chk("rnd uflow", int'(uf1), 0);
          last1 = exp_deck[idx];
          idx++;
        end else if (r) begin
          chk("rnd uflow", int'(uf1), 1);
          chk("rnd valid", int'(v1), 0);
          chk("rnd card", int'(card1), last1);
        end else begin
          chk("rnd valid", int'(v1), 0);
          chk("rnd uflow", int'(uf1), 0);
          chk("rnd card", int'(card1), last1);
        end
        chk("rnd left", int'(left1), 52 - idx);
        chk("rnd ready", int'(rdy1), (idx < 52) ? 1 : 0);
        chk("rnd empty", int'(emp1), (idx == 52) ? 1 : 0);
      end
      req1 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
